// File: rtl/sequencer_if.sv
// Control/status bundle between the control signal generator and the instruction sequencer.
interface sequencer_if;
    logic        run;
    logic [2:0]  ir_opcode;
    logic        start_fetch;
    logic        start_execute;
    logic        fetch;
    logic        clear, inc1, add, dec1, jmp, buz, load, store;
    logic        t1, t2, t3, t4, t5;
    logic        stall;
    logic        proto_err;
    logic [15:0] instr_count;

    modport master (
        output run, ir_opcode, start_fetch, start_execute,
        input  fetch, clear, inc1, add, dec1, jmp, buz, load, store,
        input  t1, t2, t3, t4, t5, stall, proto_err, instr_count
    );

    modport slave (
        input  run, ir_opcode, start_fetch, start_execute,
        output fetch, clear, inc1, add, dec1, jmp, buz, load, store,
        output t1, t2, t3, t4, t5, stall, proto_err, instr_count
    );
endinterface

// File: rtl/sequencer.sv
// FETCH/EXECUTE instruction sequencer with T1..T5 timing states, opcode decode and retire counter.
// All outputs are decoded from registers; inputs only influence the next state.
module sequencer (
    input  logic       clk,
    input  logic       rst_n,
    sequencer_if.slave bus
);
    typedef enum logic {PH_FETCH, PH_EXEC} phase_e;
    typedef enum logic [2:0] {T1, T2, T3, T4, T5} tstate_e;

    phase_e      phase_q, phase_d;
    tstate_e     t_q, t_d;
    logic [2:0]  opcode_q, opcode_d;
    logic        stall_q, stall_d;
    logic        proto_err_q, proto_err_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic        exit_req;
    logic        wrong_req;
    logic [7:0]  dec;
    logic [4:0]  t_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_FETCH;
            t_q           <= T1;
            opcode_q      <= 3'd0;
            stall_q       <= 1'b0;
            proto_err_q   <= 1'b0;
            instr_count_q <= 16'd0;
        end else begin
            phase_q       <= phase_d;
            t_q           <= t_d;
            opcode_q      <= opcode_d;
            stall_q       <= stall_d;
            proto_err_q   <= proto_err_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        phase_d       = phase_q;
        t_d           = t_q;
        opcode_d      = opcode_q;
        stall_d       = stall_q;
        proto_err_d   = proto_err_q;
        instr_count_d = instr_count_q;
        exit_req      = 1'b0;
        wrong_req     = 1'b0;

        if (bus.run) begin
            // Only the request that leaves the current phase is honoured; the other is a protocol error.
            if (phase_q == PH_FETCH) begin
                opcode_d  = bus.ir_opcode;
                exit_req  = bus.start_execute;
                wrong_req = bus.start_fetch;
            end else begin
                exit_req  = bus.start_fetch;
                wrong_req = bus.start_execute;
            end

            if (wrong_req) begin
                proto_err_d = 1'b1;
            end

            if (exit_req) begin
                t_d = T1;
                if (phase_q == PH_FETCH) begin
                    phase_d = PH_EXEC;
                end else begin
                    phase_d       = PH_FETCH;
                    instr_count_d = instr_count_q + 16'd1;
                end
            end else begin
                case (t_q)
                    T1:      t_d = T2;
                    T2:      t_d = T3;
                    T3:      t_d = T4;
                    default: t_d = T5;
                endcase
            end

            // Registered so that stall mirrors "sitting in T5 with no honoured request".
            stall_d = (t_d == T5);
        end
    end

    always_comb begin
        dec = 8'd0;
        if (phase_q == PH_EXEC) begin
            dec[opcode_q] = 1'b1;
        end
    end

    always_comb begin
        t_vec = 5'd0;
        case (t_q)
            T1:      t_vec[0] = 1'b1;
            T2:      t_vec[1] = 1'b1;
            T3:      t_vec[2] = 1'b1;
            T4:      t_vec[3] = 1'b1;
            default: t_vec[4] = 1'b1;
        endcase
    end

    assign bus.fetch       = (phase_q == PH_FETCH);
    assign bus.clear       = dec[0];
    assign bus.inc1        = dec[1];
    assign bus.add         = dec[2];
    assign bus.dec1        = dec[3];
    assign bus.jmp         = dec[4];
    assign bus.buz         = dec[5];
    assign bus.load        = dec[6];
    assign bus.store       = dec[7];
    assign bus.t1          = t_vec[0];
    assign bus.t2          = t_vec[1];
    assign bus.t3          = t_vec[2];
    assign bus.t4          = t_vec[3];
    assign bus.t5          = t_vec[4];
    assign bus.stall       = stall_q;
    assign bus.proto_err   = proto_err_q;
    assign bus.instr_count = instr_count_q;
endmodule

// File: tb/tb_sequencer.sv
// Directed table-driven bench for the sequencer plus hand-written reset, run-freeze and wrap sequences.
module tb_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    sequencer_if bus();

    sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        run;
        logic [2:0]  opc;
        logic        sf;
        logic        se;
        logic        efetch;
        logic [7:0]  edec;
        logic [4:0]  et;
        logic        estall;
        logic        eperr;
        logic [15:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic ef, input logic [7:0] ed,
                       input logic [4:0] et, input logic es, input logic ep,
                       input logic [15:0] ec);
        logic [31:0] act;
        logic [31:0] exp;
        act = {bus.fetch,
               bus.store, bus.load, bus.buz, bus.jmp, bus.dec1, bus.add, bus.inc1, bus.clear,
               bus.t5, bus.t4, bus.t3, bus.t2, bus.t1,
               bus.stall, bus.proto_err, bus.instr_count};
        exp = {ef, ed, et, es, ep, ec};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got fetch/dec/t/stall/perr/cnt=%h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [2:0] o, input logic sf, input logic se);
        bus.run           = r;
        bus.ir_opcode     = o;
        bus.start_fetch   = sf;
        bus.start_execute = se;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drive(1'b0, 3'd0, 1'b0, 1'b0);

        // run, opc, sf, se | fetch, dec, t, stall, perr, cnt
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 5'h02, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 5'h04, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 5'h08, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 5'h10, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 5'h10, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 5'h10, 1'b1, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 8'h20, 5'h01, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 8'h20, 5'h02, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 8'h20, 5'h04, 1'b0, 1'b0, 16'd0});
        vecs.push_back('{1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 5'h02, 1'b0, 1'b0, 16'd1});
        vecs.push_back('{1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00, 5'h04, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 5'h08, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 8'h40, 5'h01, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 8'h40, 5'h02, 1'b0, 1'b1, 16'd1});
        vecs.push_back('{1'b1, 3'd6, 1'b1, 1'b1, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h01, 5'h01, 1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 8'h01, 5'h02, 1'b0, 1'b1, 16'd2});
        vecs.push_back('{1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd3});
        vecs.push_back('{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 8'h02, 5'h01, 1'b0, 1'b1, 16'd3});
        vecs.push_back('{1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd4});
        vecs.push_back('{1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 8'h10, 5'h01, 1'b0, 1'b1, 16'd4});
        vecs.push_back('{1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 8'h10, 5'h01, 1'b0, 1'b1, 16'd4});
        vecs.push_back('{1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 8'h10, 5'h02, 1'b0, 1'b1, 16'd4});
        vecs.push_back('{1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd5});
        vecs.push_back('{1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 8'h04, 5'h01, 1'b0, 1'b1, 16'd5});
        vecs.push_back('{1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd6});
        vecs.push_back('{1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 8'h08, 5'h01, 1'b0, 1'b1, 16'd6});
        vecs.push_back('{1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd7});
        vecs.push_back('{1'b1, 3'd7, 1'b0, 1'b1, 1'b0, 8'h80, 5'h01, 1'b0, 1'b1, 16'd7});
        vecs.push_back('{1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 8'h00, 5'h01, 1'b0, 1'b1, 16'd8});

        #3;
        chk("reset_async", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd0);
        step();
        chk("reset_held", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].run, vecs[i].opc, vecs[i].sf, vecs[i].se);
            step();
            chk($sformatf("vec%0d", i), vecs[i].efetch, vecs[i].edec, vecs[i].et,
                vecs[i].estall, vecs[i].eperr, vecs[i].ecnt);
        end

        // Reset clears sticky error and counter; then freeze with a pending start_fetch.
        drive(1'b1, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("reset_clears", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 1'b1);
        step();
        chk("enter_exec", 1'b0, 8'h02, 5'h01, 1'b0, 1'b0, 16'd0);
        drive(1'b1, 3'd1, 1'b0, 1'b0);
        step();
        chk("exec_t2", 1'b0, 8'h02, 5'h02, 1'b0, 1'b0, 16'd0);
        drive(1'b0, 3'd6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("frozen%0d", i), 1'b0, 8'h02, 5'h02, 1'b0, 1'b0, 16'd0);
        end
        drive(1'b1, 3'd6, 1'b1, 1'b0);
        step();
        chk("unfreeze_retire", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd1);

        // Bring count to 3, then abandon an instruction in EXECUTE T4 with an async reset.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'd2, 1'b0, 1'b1);
            step();
            drive(1'b1, 3'd2, 1'b1, 1'b0);
            step();
        end
        chk("count3", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd3);
        drive(1'b1, 3'd2, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'd2, 1'b0, 1'b0);
        step();
        step();
        step();
        chk("exec_t4", 1'b0, 8'h04, 5'h08, 1'b0, 1'b0, 16'd3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_exec", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("first_edge_after_reset", 1'b1, 8'h00, 5'h02, 1'b0, 1'b0, 16'd0);

        // Preload the counter near the top to exercise wrap without 65535 real instructions.
        drive(1'b0, 3'd0, 1'b0, 1'b0);
        force dut.instr_count_q = 16'hFFFE;
        #1;
        release dut.instr_count_q;
        drive(1'b1, 3'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'd0, 1'b1, 1'b0);
        step();
        chk("count_ffff", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'hFFFF);
        drive(1'b1, 3'd0, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'd0, 1'b1, 1'b0);
        step();
        chk("count_wrap", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'h0000);

        // Stall inside EXECUTE, released by start_fetch.
        drive(1'b1, 3'd6, 1'b0, 1'b1);
        step();
        drive(1'b1, 3'd6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step();
        chk("exec_stall", 1'b0, 8'h40, 5'h10, 1'b1, 1'b0, 16'h0000);
        drive(1'b1, 3'd6, 1'b1, 1'b0);
        step();
        chk("exec_stall_release", 1'b1, 8'h00, 5'h01, 1'b0, 1'b0, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
